// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell fed LSB-first from two operand shift
// registers, with a carry flop closing the loop; one sum bit per clock.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic fa_sum(input logic x, input logic y, input logic ci);
    return x ^ y ^ ci;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic ci);
    return (x & y) | (x & ci) | (y & ci);
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] x_sr_r;
  logic [WIDTH-1:0] y_sr_r;
  logic [WIDTH-1:0] sr_sum_r;
  logic [WIDTH-1:0] sum_r;
  logic             cy_r;
  logic             c_out_r;
  logic [CW-1:0]    cnt_r;
  logic             load_s;
  logic             last_s;
  logic             bit_sum_s;
  logic             bit_carry_s;
  logic [WIDTH:0]   sum_shift_s;

  assign bit_sum_s   = fa_sum(x_sr_r[0], y_sr_r[0], cy_r);
  assign bit_carry_s = fa_carry(x_sr_r[0], y_sr_r[0], cy_r);
  // New bit enters at the MSB; the widened vector keeps WIDTH==1 legal.
  assign sum_shift_s = {bit_sum_s, sr_sum_r};

  assign busy  = (state_r == RUN);
  assign done  = (state_r == DONE);
  assign sum   = sum_r;
  assign c_out = c_out_r;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; a start seen in DONE reloads directly for back-to-back adds
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    last_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s  = 1'b1;
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST) begin
          last_s  = 1'b1;
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          load_s  = 1'b1;
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Operand shift, carry loop, bit counter and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      x_sr_r   <= '0;
      y_sr_r   <= '0;
      sr_sum_r <= '0;
      sum_r    <= '0;
      cy_r     <= 1'b0;
      c_out_r  <= 1'b0;
      cnt_r    <= '0;
    end else if (load_s) begin
      x_sr_r   <= a;
      y_sr_r   <= b;
      cy_r     <= c_in;
      cnt_r    <= '0;
      sr_sum_r <= '0;
    end else if (state_r == RUN) begin
      x_sr_r   <= x_sr_r >> 1;
      y_sr_r   <= y_sr_r >> 1;
      cy_r     <= bit_carry_s;
      sr_sum_r <= sum_shift_s[WIDTH:1];
      cnt_r    <= cnt_r + CW'(1);
      if (last_s) begin
        sum_r   <= sum_shift_s[WIDTH:1];
        c_out_r <= bit_carry_s;
      end
    end
  end

endmodule
